tick_timer: RTL and testbench

Periodic timer-interrupt generator that consumes the divided 1 s toggle produced by the clock-divider stage (`clk1s`). It converts that slow square wave into single-cycle ticks and counts ticks down from a software-programmed reload value. It raises a level interrupt that software must acknowledge, and it keeps a free-running uptime tick count for the OS scheduler and status display.

---
 rtl/tick_timer.sv | 126 ++++++++++++
 tb/tb_tick_timer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/tick_timer.sv
// tick_timer
//   Periodic timer-interrupt generator driven by the divided 1 s toggle
//   from the clock-divider stage. Each rising edge of tick_in is turned
//   into a single-cycle tick. Ticks count down from a programmable reload
//   value, and when the countdown expires the block raises a level
//   interrupt that is held until software acknowledges it. A free-running
//   32-bit uptime counter records every tick since reset.
//
// Parameters
//   W       width of the reload value and the countdown counter
//   MISS_W  width of the saturating missed-interrupt counter
//
// Ports
//   clk         in   system clock (same clock as the divider stage)
//   rst         in   synchronous, active-high reset
//   tick_in     in   slow toggle from the divider, already synchronous to clk
//   enable      in   1 = countdown runs, 0 = stopped
//   reload_we   in   one-cycle write strobe for reload_val
//   reload_val  in   ticks per interrupt; 0 means never fire
//   irq_ack     in   one-cycle acknowledge from the interrupt controller
//   irq         out  interrupt level, held until acknowledged
//   count       out  current countdown value
//   missed      out  fires that occurred while irq was already pending (saturating)
//   uptime      out  total ticks since reset (wraps)
module tick_timer #(
    parameter int W      = 16,
    parameter int MISS_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick_in,
    input  logic              enable,
    input  logic              reload_we,
    input  logic [W-1:0]      reload_val,
    input  logic              irq_ack,
    output logic              irq,
    output logic [W-1:0]      count,
    output logic [MISS_W-1:0] missed,
    output logic [31:0]       uptime
);

    typedef enum logic {
        STOP = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t       state;
    logic         tick_d;
    logic         tick;
    logic         fire;
    logic [W-1:0] reload;

    // Saturating increment for the missed-interrupt counter.
    function automatic logic [MISS_W-1:0] sat_inc(input logic [MISS_W-1:0] v);
        logic [MISS_W-1:0] r;
        r = (&v) ? v : v + 1'b1;
        return r;
    endfunction

    // tick_d resets to 1 so a tick_in that is already high out of reset
    // does not count; a real tick needs a low-then-high sequence.
    assign tick = tick_in & ~tick_d;

    // A write strobe takes priority over the countdown, so a tick that
    // coincides with reload_we never fires. count[W-1:1]==0 is count<=1.
    assign fire = (state == RUN) && enable && tick && !reload_we &&
                  (reload != '0) && (count[W-1:1] == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= STOP;
            tick_d <= 1'b1;
            reload <= '0;
            count  <= '0;
            irq    <= 1'b0;
            missed <= '0;
            uptime <= '0;
        end else begin
            tick_d <= tick_in;

            // Uptime counts every tick, whether or not the countdown runs.
            if (tick) begin
                uptime <= uptime + 32'd1;
            end

            if (reload_we) begin
                reload <= reload_val;
                count  <= reload_val;
                missed <= '0;
            end

            case (state)
                STOP: begin
                    // While stopped the counter is held at the reload value,
                    // so the first RUN cycle starts from a full period.
                    if (!reload_we) begin
                        count <= reload;
                    end
                    if (enable) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (!enable) begin
                        state <= STOP;
                    end else if (!reload_we && tick && (reload != '0)) begin
                        count <= fire ? reload : count - 1'b1;
                    end
                end
                default: state <= STOP;
            endcase

            // A fire coincident with an ack: the ack retires the old event
            // and the new fire keeps irq set, so nothing counts as missed.
            if (fire) begin
                irq <= 1'b1;
                if (irq && !irq_ack) begin
                    missed <= sat_inc(missed);
                end
            end else if (irq_ack) begin
                irq <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_tick_timer.sv
module tb_tick_timer;

    localparam int W = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          tick_in = 1'b1;
    logic          enable = 1'b0;
    logic          reload_we = 1'b0;
    logic [W-1:0]  reload_val = '0;
    logic          irq_ack = 1'b0;
    logic          irq;
    logic [W-1:0]  count;
    logic [7:0]    missed;
    logic [31:0]   uptime;

    logic          irq_s;
    logic [W-1:0]  count_s;
    logic [1:0]    missed_s;
    logic [31:0]   uptime_s;

    int total = 0;
    int bad   = 0;

    tick_timer #(.W(W), .MISS_W(8)) dut (
        .clk(clk), .rst(rst), .tick_in(tick_in), .enable(enable),
        .reload_we(reload_we), .reload_val(reload_val), .irq_ack(irq_ack),
        .irq(irq), .count(count), .missed(missed), .uptime(uptime)
    );

    // Narrow missed counter instance to exercise saturation.
    tick_timer #(.W(W), .MISS_W(2)) dut_s (
        .clk(clk), .rst(rst), .tick_in(tick_in), .enable(enable),
        .reload_we(reload_we), .reload_val(reload_val), .irq_ack(irq_ack),
        .irq(irq_s), .count(count_s), .missed(missed_s), .uptime(uptime_s)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Low then high: the tick is seen in the high cycle, results visible after.
    task automatic pulse();
        tick_in = 1'b0;
        cyc();
        tick_in = 1'b1;
        cyc();
    endtask

    task automatic do_reset();
        rst = 1'b1; tick_in = 1'b0; enable = 1'b0; reload_we = 1'b0;
        reload_val = '0; irq_ack = 1'b0;
        cyc(); cyc();
        rst = 1'b0;
    endtask

    task automatic write_reload(input logic [W-1:0] v);
        reload_we = 1'b1; reload_val = v;
        cyc();
        reload_we = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; tick_in = 1'b1;
        repeat (5) cyc();
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq got=%0d want=0", irq); end
        total++; if (count !== 16'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", count); end
        total++; if (missed !== 8'd0) begin bad++; $display("FAIL reset_missed got=%0d want=0", missed); end
        total++; if (uptime !== 32'd0) begin bad++; $display("FAIL reset_uptime got=%0d want=0", uptime); end
        rst = 1'b0;
        repeat (5) cyc();
        total++; if (uptime !== 32'd0) begin bad++; $display("FAIL held_high_uptime got=%0d want=0", uptime); end
        tick_in = 1'b0;
        cyc();
        total++; if (uptime !== 32'd0) begin bad++; $display("FAIL fall_uptime got=%0d want=0", uptime); end
        tick_in = 1'b1;
        cyc();
        total++; if (uptime !== 32'd1) begin bad++; $display("FAIL first_tick_uptime got=%0d want=1", uptime); end
        repeat (4) cyc();
        total++; if (uptime !== 32'd1) begin bad++; $display("FAIL long_high_uptime got=%0d want=1", uptime); end
    endtask

    task automatic test_periodic();
        int pulses;
        logic [W-1:0] exp_cnt;
        logic exp_irq;
        pulses = 0;
        do_reset();
        write_reload(16'd3);
        total++; if (count !== 16'd3) begin bad++; $display("FAIL per_load_count got=%0d want=3", count); end
        enable = 1'b1;
        cyc();
        total++; if (count !== 16'd3) begin bad++; $display("FAIL per_run_count got=%0d want=3", count); end
        for (int i = 1; i <= 9; i++) begin
            pulse();
            exp_irq = (i % 3 == 0);
            exp_cnt = (i % 3 == 0) ? 16'd3 : 16'(3 - (i % 3));
            total++; if (count !== exp_cnt) begin bad++; $display("FAIL per_count tick=%0d got=%0d want=%0d", i, count, exp_cnt); end
            total++; if (irq !== exp_irq) begin bad++; $display("FAIL per_irq tick=%0d got=%0d want=%0d", i, irq, exp_irq); end
            if (irq === 1'b1) pulses++;
            irq_ack = irq;
            cyc();
            irq_ack = 1'b0;
            total++; if (irq !== 1'b0) begin bad++; $display("FAIL per_ack tick=%0d got=%0d want=0", i, irq); end
            cyc();
        end
        total++; if (pulses != 3) begin bad++; $display("FAIL per_pulses got=%0d want=3", pulses); end
        total++; if (uptime !== 32'd9) begin bad++; $display("FAIL per_uptime got=%0d want=9", uptime); end
        total++; if (missed !== 8'd0) begin bad++; $display("FAIL per_missed got=%0d want=0", missed); end
    endtask

    task automatic test_missed();
        do_reset();
        write_reload(16'd1);
        enable = 1'b1;
        cyc();
        pulse();
        total++; if (irq !== 1'b1) begin bad++; $display("FAIL miss_irq1 got=%0d want=1", irq); end
        total++; if (missed !== 8'd0) begin bad++; $display("FAIL miss_first got=%0d want=0", missed); end
        repeat (4) pulse();
        total++; if (missed !== 8'd4) begin bad++; $display("FAIL miss_five got=%0d want=4", missed); end
        total++; if (missed_s !== 2'd3) begin bad++; $display("FAIL miss_sat5 got=%0d want=3", missed_s); end
        repeat (5) pulse();
        total++; if (missed !== 8'd9) begin bad++; $display("FAIL miss_ten got=%0d want=9", missed); end
        total++; if (missed_s !== 2'd3) begin bad++; $display("FAIL miss_sat10 got=%0d want=3", missed_s); end
        total++; if (uptime !== 32'd10) begin bad++; $display("FAIL miss_uptime got=%0d want=10", uptime); end
    endtask

    // Continues from test_missed: irq pending, reload 1, missed 9.
    task automatic test_fire_ack();
        tick_in = 1'b0;
        cyc();
        tick_in = 1'b1; irq_ack = 1'b1;
        cyc();
        irq_ack = 1'b0;
        total++; if (irq !== 1'b1) begin bad++; $display("FAIL fa_irq got=%0d want=1", irq); end
        total++; if (missed !== 8'd9) begin bad++; $display("FAIL fa_missed got=%0d want=9", missed); end
        irq_ack = 1'b1;
        cyc();
        irq_ack = 1'b0;
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL fa_ack got=%0d want=0", irq); end
        irq_ack = 1'b1;
        cyc();
        irq_ack = 1'b0;
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL fa_idle_ack got=%0d want=0", irq); end
        total++; if (missed !== 8'd9) begin bad++; $display("FAIL fa_idle_missed got=%0d want=9", missed); end
    endtask

    task automatic test_disable();
        do_reset();
        write_reload(16'd2);
        enable = 1'b1;
        cyc();
        pulse();
        total++; if (count !== 16'd1) begin bad++; $display("FAIL dis_count1 got=%0d want=1", count); end
        enable = 1'b0;
        cyc(); cyc();
        repeat (4) pulse();
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL dis_irq got=%0d want=0", irq); end
        total++; if (count !== 16'd2) begin bad++; $display("FAIL dis_count got=%0d want=2", count); end
        total++; if (uptime !== 32'd5) begin bad++; $display("FAIL dis_uptime got=%0d want=5", uptime); end
        enable = 1'b1;
        cyc();
        pulse();
        total++; if (irq !== 1'b0 || count !== 16'd1) begin bad++; $display("FAIL dis_re1 irq=%0d count=%0d want irq=0 count=1", irq, count); end
        pulse();
        total++; if (irq !== 1'b1) begin bad++; $display("FAIL dis_fire got=%0d want=1", irq); end
        total++; if (count !== 16'd2) begin bad++; $display("FAIL dis_fire_count got=%0d want=2", count); end
        // Stopping must not drop a pending interrupt.
        enable = 1'b0;
        repeat (3) cyc();
        total++; if (irq !== 1'b1) begin bad++; $display("FAIL dis_keep_irq got=%0d want=1", irq); end
    endtask

    task automatic test_reload();
        logic seen;
        seen = 1'b0;
        do_reset();
        enable = 1'b1;
        cyc();
        for (int i = 0; i < 10; i++) begin
            pulse();
            if (irq !== 1'b0) seen = 1'b1;
        end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL rl_zero_irq got=%0d want=0", seen); end
        total++; if (uptime !== 32'd10) begin bad++; $display("FAIL rl_zero_uptime got=%0d want=10", uptime); end
        write_reload(16'd1);
        repeat (3) pulse();
        total++; if (missed !== 8'd2) begin bad++; $display("FAIL rl_pre_missed got=%0d want=2", missed); end
        tick_in = 1'b0;
        cyc();
        tick_in = 1'b1; reload_we = 1'b1; reload_val = 16'd5;
        cyc();
        reload_we = 1'b0;
        total++; if (count !== 16'd5) begin bad++; $display("FAIL rl_we_count got=%0d want=5", count); end
        total++; if (missed !== 8'd0) begin bad++; $display("FAIL rl_we_missed got=%0d want=0", missed); end
        total++; if (uptime !== 32'd14) begin bad++; $display("FAIL rl_we_uptime got=%0d want=14", uptime); end
        total++; if (irq !== 1'b1) begin bad++; $display("FAIL rl_we_irq got=%0d want=1", irq); end
        pulse();
        total++; if (count !== 16'd4) begin bad++; $display("FAIL rl_next_count got=%0d want=4", count); end
    endtask

    // Continues from test_reload with irq pending and tick_in high.
    task automatic test_mid_reset();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL mr_irq got=%0d want=0", irq); end
        total++; if (count !== 16'd0) begin bad++; $display("FAIL mr_count got=%0d want=0", count); end
        total++; if (uptime !== 32'd0) begin bad++; $display("FAIL mr_uptime got=%0d want=0", uptime); end
        cyc(); cyc();
        total++; if (uptime !== 32'd0) begin bad++; $display("FAIL mr_no_tick got=%0d want=0", uptime); end
    endtask

    initial begin
        test_reset();
        test_periodic();
        test_missed();
        test_fire_ack();
        test_disable();
        test_reload();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
